time_counter: RTL

TIME_COUNTER -- requirements
Module: time_counter

---
 rtl/time_counter.sv | 117 +++++++++++
 1 files changed

// File: rtl/time_counter.sv
// time_counter: 24-hour hh:mm:ss time-of-day counter.
// Advances one second per seconds strobe while run is high, accepts a
// validated hour/minute load, and flags each second and each midnight wrap.
// Optional build macro PRESCALER_EN: when defined, the seconds strobe is
// generated internally from CLK_FREQ and the tick_1hz port is removed.
module time_counter #(
  parameter int unsigned CLK_FREQ = 100000000
) (
  input  logic        clk,
  input  logic        rst,
`ifdef PRESCALER_EN
`else
  input  logic        tick_1hz,
`endif
  input  logic        run,
  input  logic        set_time,
  input  logic [10:0] time_set_in,
  output logic [16:0] time_out,
  output logic [10:0] time_hm,
  output logic        sec_pulse,
  output logic        new_day
);

  // A zero-frequency clock would leave the prescaler without a terminal count.
  if (CLK_FREQ < 1) begin : g_bad_freq
    $error("time_counter: CLK_FREQ must be at least 1");
  end

  // Load value is accepted only when it names a real time of day.
  function automatic logic hm_valid(input logic [10:0] hm);
    return (hm[10:6] <= 5'd23) && (hm[5:0] <= 6'd59);
  endfunction

  logic [4:0] hour_p1;
  logic [5:0] min_p1;
  logic [5:0] sec_p1;
  logic       sec_pulse_p1;
  logic       new_day_p1;

  logic       strobe_p0;
  logic       load_p0;
  logic       adv_p0;

  // ---- stage p0: decide this cycle's action (load wins over a strobe) ----
  assign load_p0 = set_time && hm_valid(time_set_in);
  assign adv_p0  = run && !set_time && strobe_p0;

`ifdef PRESCALER_EN
  localparam int unsigned CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] pre_cnt;

  // Prescaler: counts clocks while running, restarts on every accepted load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (load_p0) begin
      pre_cnt <= '0;
    end else if (run) begin
      if (pre_cnt == PRE_LAST) begin
        pre_cnt <= '0;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  assign strobe_p0 = run && (pre_cnt == PRE_LAST);
`else
  assign strobe_p0 = tick_1hz;
`endif

  // ---- stage p1: time registers and event flags ----
  // Time-of-day update with cascaded carries; flags last exactly one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hour_p1      <= '0;
      min_p1       <= '0;
      sec_p1       <= '0;
      sec_pulse_p1 <= 1'b0;
      new_day_p1   <= 1'b0;
    end else begin
      sec_pulse_p1 <= 1'b0;
      new_day_p1   <= 1'b0;
      if (load_p0) begin
        hour_p1 <= time_set_in[10:6];
        min_p1  <= time_set_in[5:0];
        sec_p1  <= '0;
      end else if (adv_p0) begin
        sec_pulse_p1 <= 1'b1;
        if (sec_p1 == 6'd59) begin
          sec_p1 <= '0;
          if (min_p1 == 6'd59) begin
            min_p1 <= '0;
            if (hour_p1 == 5'd23) begin
              hour_p1    <= '0;
              new_day_p1 <= 1'b1;
            end else begin
              hour_p1 <= hour_p1 + 5'd1;
            end
          end else begin
            min_p1 <= min_p1 + 6'd1;
          end
        end else begin
          sec_p1 <= sec_p1 + 6'd1;
        end
      end
    end
  end

  assign time_out  = {hour_p1, min_p1, sec_p1};
  assign time_hm   = {hour_p1, min_p1};
  assign sec_pulse = sec_pulse_p1;
  assign new_day   = new_day_p1;

endmodule
